timer_master_seq: RTL and testbench
===================================

TIMER_MASTER_SEQ -- requirements
Module: timer_master_seq

Interface
REQ-001 SHALL have parameter TICK_W, default 32: width of tick_count.
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_start  input  1  one-cycle pulse: program `period` and start the timer.
REQ-005 SHALL have port cmd_stop  input  1  one-cycle pulse: stop the timer.
REQ-006 SHALL have port cmd_snap  input  1  one-cycle pulse: request a counter snapshot.
REQ-007 SHALL have port period  input  32  timer reload value, sampled with cmd_start.
REQ-008 SHALL have port tick_count  output  TICK_W  count of acknowledged timeouts.
REQ-009 SHALL have port running  output  1  timer is programmed and started.
REQ-010 SHALL have port busy  output  1  FSM is not in IDLE.
REQ-011 SHALL have port snap_value  output  32  last snapshot, {high, low}.
REQ-012 SHALL have port snap_valid  output  1  one-cycle pulse when snap_value updates.
REQ-013 SHALL have port avm_address  output  3  timer register address.
REQ-014 SHALL have port avm_chipselect  output  1  bus access.
REQ-015 SHALL have port avm_write_n  output  1  low marks a write.
REQ-016 SHALL have port avm_writedata  output  16  write data.
REQ-017 SHALL have port avm_readdata  input  16  registered read data, valid the cycle after the address.
REQ-018 SHALL have port timer_irq  input  1  timer interrupt, level.

Function
REQ-019 SHALL drive the idle bus whenever it is not accessing: chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 SHALL make each bus access last exactly one cycle; the slave has no waitrequest.
REQ-021 SHALL implement these states: IDLE, STOP0, PL, PH, CLR0, CTRL, RUN, ACK, SNAPW, SNAPL, SNAPH, SNAPD, HALT.
REQ-022 IDLE: cmd_start SHALL latch period, clear tick_count, and go to STOP0; cmd_stop and cmd_snap SHALL be ignored in IDLE.
REQ-023 STOP0 SHALL write addr 1 = 0x0008; PL SHALL write addr 2 = period[15:0]; PH SHALL write addr 3 = period[31:16]; CLR0 SHALL write addr 0 = 0x0000; CTRL SHALL write addr 1 = 0x0007 and then go to RUN. Each state advances after 1 cycle.
REQ-024 running SHALL go to 1 on entry to RUN from CTRL and to 0 on exit from HALT.
REQ-025 RUN priority SHALL be stop_pend > timer_irq > snap_pend: stop_pend goes to HALT, timer_irq goes to ACK, snap_pend goes to SNAPW; otherwise RUN holds with the bus idle.
REQ-026 ACK SHALL write addr 0 = 0x0000, increment tick_count modulo 2^TICK_W, and return to RUN. The irq drops by the next cycle, so each timeout counts exactly once.
REQ-027 SNAPW SHALL write addr 4 (data 0). SNAPL SHALL read addr 4. SNAPH SHALL read addr 5 and capture avm_readdata as the low half. SNAPD SHALL capture the high half, update snap_value, pulse snap_valid, and return to RUN.
REQ-028 HALT SHALL write addr 1 = 0x0008 and go to IDLE.
REQ-029 cmd_stop in any state other than IDLE SHALL set stop_pend; stop_pend SHALL clear in HALT.
REQ-030 cmd_snap in any state other than IDLE or HALT SHALL set snap_pend; snap_pend SHALL clear in SNAPW; repeated requests merge into one.
REQ-031 cmd_start outside IDLE SHALL be ignored.
REQ-032 busy SHALL equal (state != IDLE).

Reset
REQ-033 reset_n low SHALL asynchronously force: state=IDLE, tick_count=0, running=0, snap_value=0, snap_valid=0, stop_pend=0, snap_pend=0, latched period=0, and the idle bus values.
REQ-034 Reset mid-sequence SHALL abandon the sequence; the block issues no further bus access until the next cmd_start.

Structure
REQ-035 A shared package SHALL hold the state enum, register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5), and control words (CTRL_STOP=0x0008, CTRL_RUN=0x0007).
REQ-036 The block SHALL be a single module with one FSM; no sub-module.

Verification
REQ-037 Reset, then cmd_start with period=0x0001_86A0 -> over 5 cycles writes (1,0x0008), (2,0x86A0), (3,0x0001), (0,0x0000), (1,0x0007); then running=1.
REQ-038 In RUN, timer_irq high for 2 cycles, three times -> three addr-0 writes; tick_count=3.
REQ-039 With TICK_W=4 and tick_count=15, one irq -> tick_count=0.
REQ-040 cmd_snap with readdata 0x1234 (addr 4) then 0x0005 (addr 5) -> snap_value=0x0005_1234 with a 1-cycle snap_valid pulse.
REQ-041 cmd_stop during SNAPL -> snapshot completes, then HALT writes (1,0x0008); running=0; busy=0.
REQ-042 timer_irq and cmd_stop in the same RUN cycle -> HALT is taken and tick_count is unchanged; reset asserted during PH -> idle bus immediately and all outputs 0.

Source files
------------

// File: rtl/timer_master_seq_pkg.sv
// Shared definitions for the timer master sequencer: FSM states, timer
// register map, control words and bus-cycle helpers.
package timer_master_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_STOP0, ST_PL, ST_PH, ST_CLR0, ST_CTRL, ST_RUN,
        ST_ACK, ST_SNAPW, ST_SNAPL, ST_SNAPH, ST_SNAPD, ST_HALT
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam logic [15:0] CTRL_STOP = 16'h0008;
    localparam logic [15:0] CTRL_RUN  = 16'h0007;

    typedef struct packed {
        logic        chipselect;
        logic        write_n;
        logic [2:0]  address;
        logic [15:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1, address: 3'd0, writedata: 16'h0000};

    function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        return '{chipselect: 1'b1, write_n: 1'b0, address: addr, writedata: data};
    endfunction

    function automatic bus_t bus_read(input logic [2:0] addr);
        return '{chipselect: 1'b1, write_n: 1'b1, address: addr, writedata: 16'h0000};
    endfunction

endpackage

// File: rtl/timer_master_seq.sv
// Bus master that programs an interval timer, counts acknowledged timeouts
// and takes coherent {high, low} counter snapshots on request.
module timer_master_seq
    import timer_master_seq_pkg::*;
#(
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    input  logic [31:0]       period,
    output logic [TICK_W-1:0] tick_count,
    output logic              running,
    output logic              busy,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq
);

    state_t      state;
    bus_t        bus;
    logic        stop_pend;
    logic        snap_pend;
    logic [31:0] period_q;
    logic [15:0] snap_lo;
    logic        stop_req;
    logic        snap_req;

    // A command arriving in the RUN cycle itself is honoured without waiting
    // for its pending flag to register.
    assign stop_req = stop_pend | cmd_stop;
    assign snap_req = snap_pend | cmd_snap;

    assign busy = (state != ST_IDLE);
    assign {avm_chipselect, avm_write_n, avm_address, avm_writedata} = bus;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bus        <= BUS_IDLE;
            tick_count <= '0;
            running    <= 1'b0;
            snap_value <= '0;
            snap_valid <= 1'b0;
            stop_pend  <= 1'b0;
            snap_pend  <= 1'b0;
            period_q   <= '0;
            snap_lo    <= '0;
        end else begin
            // NOTE: the bus register is loaded on the edge that enters a state,
            // so each state's access is driven for exactly that state's cycle;
            // every path not overriding it returns the bus to idle.
            bus        <= BUS_IDLE;
            snap_valid <= 1'b0;

            // NOTE: these sets precede the case statement on purpose; the clears
            // in SNAPW and HALT below are later non-blocking writes and win.
            if (cmd_stop && state != ST_IDLE)
                stop_pend <= 1'b1;
            if (cmd_snap && state != ST_IDLE && state != ST_HALT)
                snap_pend <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        period_q   <= period;
                        tick_count <= '0;
                        state      <= ST_STOP0;
                        bus        <= bus_write(ADDR_CONTROL, CTRL_STOP);
                    end
                end
                ST_STOP0: begin
                    state <= ST_PL;
                    bus   <= bus_write(ADDR_PERIODL, period_q[15:0]);
                end
                ST_PL: begin
                    state <= ST_PH;
                    bus   <= bus_write(ADDR_PERIODH, period_q[31:16]);
                end
                ST_PH: begin
                    state <= ST_CLR0;
                    bus   <= bus_write(ADDR_STATUS, 16'h0000);
                end
                ST_CLR0: begin
                    state <= ST_CTRL;
                    bus   <= bus_write(ADDR_CONTROL, CTRL_RUN);
                end
                ST_CTRL: begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state <= ST_HALT;
                        bus   <= bus_write(ADDR_CONTROL, CTRL_STOP);
                    end else if (timer_irq) begin
                        state <= ST_ACK;
                        bus   <= bus_write(ADDR_STATUS, 16'h0000);
                    end else if (snap_req) begin
                        state <= ST_SNAPW;
                        bus   <= bus_write(ADDR_SNAPL, 16'h0000);
                    end
                end
                ST_ACK: begin
                    tick_count <= tick_count + 1'b1;
                    state      <= ST_RUN;
                end
                ST_SNAPW: begin
                    snap_pend <= 1'b0;
                    state     <= ST_SNAPL;
                    bus       <= bus_read(ADDR_SNAPL);
                end
                ST_SNAPL: begin
                    state <= ST_SNAPH;
                    bus   <= bus_read(ADDR_SNAPH);
                end
                ST_SNAPH: begin
                    snap_lo <= avm_readdata;
                    state   <= ST_SNAPD;
                end
                ST_SNAPD: begin
                    snap_value <= {avm_readdata, snap_lo};
                    snap_valid <= 1'b1;
                    state      <= ST_RUN;
                end
                ST_HALT: begin
                    // A snapshot requested alongside a stop is dropped with the run.
                    stop_pend <= 1'b0;
                    snap_pend <= 1'b0;
                    running   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_master_seq.sv
// Self-checking bench for timer_master_seq: directed scenarios plus randomized
// run-phase operations scored against a transaction-level reference model.
module tb_timer_master_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start, cmd_stop, cmd_snap, timer_irq;
    logic [31:0] period;
    logic [15:0] avm_readdata;

    logic [31:0] tick_count;
    logic        running, busy, snap_valid;
    logic [31:0] snap_value;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;

    logic [3:0]  tick4;
    logic        running4, busy4, snap_valid4;
    logic [31:0] snap_value4;
    logic [2:0]  avm_address4;
    logic        avm_chipselect4, avm_write_n4;
    logic [15:0] avm_writedata4;

    always #5 clk = ~clk;

    timer_master_seq #(.TICK_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_snap(cmd_snap), .period(period), .tick_count(tick_count), .running(running),
        .busy(busy), .snap_value(snap_value), .snap_valid(snap_valid),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
    );

    timer_master_seq #(.TICK_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_snap(cmd_snap), .period(period), .tick_count(tick4), .running(running4),
        .busy(busy4), .snap_value(snap_value4), .snap_valid(snap_valid4),
        .avm_address(avm_address4), .avm_chipselect(avm_chipselect4), .avm_write_n(avm_write_n4),
        .avm_writedata(avm_writedata4), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Timer slave: registered read data for the snapshot registers, garbage otherwise.
    logic [15:0] slave_lo = 16'h0, slave_hi = 16'h0;
    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n && avm_address == 3'd4)
            avm_readdata <= slave_lo;
        else if (avm_chipselect && avm_write_n && avm_address == 3'd5)
            avm_readdata <= slave_hi;
        else
            avm_readdata <= 16'($urandom());
    end

    // Bus monitor: entries are {is_write, address, write data or 0 for reads}.
    int          cycle_no = 0;
    int          valid_pulses = 0, valid_pulses4 = 0;
    logic [19:0] act_q[$], act4_q[$];
    int          act_t[$];
    always @(negedge clk) begin
        cycle_no++;
        if (snap_valid)  valid_pulses++;
        if (snap_valid4) valid_pulses4++;
        if (avm_chipselect) begin
            act_q.push_back({~avm_write_n, avm_address, avm_write_n ? 16'h0 : avm_writedata});
            act_t.push_back(cycle_no);
        end else
            check("idle_bus", 64'({avm_write_n, avm_address, avm_writedata}), 64'({1'b1, 3'd0, 16'h0}));
        if (avm_chipselect4)
            act4_q.push_back({~avm_write_n4, avm_address4, avm_write_n4 ? 16'h0 : avm_writedata4});
        else
            check("idle_bus4", 64'({avm_write_n4, avm_address4, avm_writedata4}), 64'({1'b1, 3'd0, 16'h0}));
    end

    // Reference model state.
    logic [31:0] m_tick = 32'h0;
    logic [31:0] m_snap = 32'h0;
    int          m_pulses = 0;
    logic [19:0] exp_q[$];

    function automatic void exp_write(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({1'b1, a, d});
    endfunction

    function automatic void exp_read(input logic [2:0] a);
        exp_q.push_back({1'b0, a, 16'h0});
    endfunction

    function automatic void exp_snapshot(input logic [15:0] lo, input logic [15:0] hi);
        exp_write(3'd4, 16'h0);
        exp_read(3'd4);
        exp_read(3'd5);
        m_snap = {hi, lo};
        m_pulses++;
    endfunction

    task automatic compare_bus(input string tag);
        check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        check({tag, "_count4"}, 64'(act4_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size())  check(tag, 64'(act_q[i]), 64'(exp_q[i]));
            if (i < act4_q.size()) check({tag, "4"}, 64'(act4_q[i]), 64'(exp_q[i]));
        end
        act_q.delete();
        act4_q.delete();
        act_t.delete();
        exp_q.delete();
    endtask

    task automatic check_ticks(input string tag);
        check(tag, 64'(tick_count), 64'(m_tick));
        check({tag, "4"}, 64'(tick4), 64'(m_tick[3:0]));
    endtask

    task automatic check_status(input string tag, input logic exp_run, input logic exp_busy);
        check({tag, "_running"}, 64'({running, running4}), 64'({exp_run, exp_run}));
        check({tag, "_busy"}, 64'({busy, busy4}), 64'({exp_busy, exp_busy}));
    endtask

    task automatic check_snap(input string tag, input logic exp_valid);
        check({tag, "_value"}, 64'(snap_value), 64'(m_snap));
        check({tag, "_value4"}, 64'(snap_value4), 64'(m_snap));
        check({tag, "_valid"}, 64'({snap_valid, snap_valid4}), 64'({exp_valid, exp_valid}));
    endtask

    // Stimulus is applied 1 ns after the falling edge.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] p);
        cmd_start = 1'b1;
        period    = p;
        cyc();
        cmd_start = 1'b0;
        period    = $urandom();
        cyc(5);
        exp_write(3'd1, 16'h0008);
        exp_write(3'd2, p[15:0]);
        exp_write(3'd3, p[31:16]);
        exp_write(3'd0, 16'h0000);
        exp_write(3'd1, 16'h0007);
        m_tick = 32'h0;
    endtask

    task automatic do_irq(input logic two_cycles);
        timer_irq = 1'b1;
        cyc();
        if (!two_cycles) timer_irq = 1'b0;
        cyc();
        timer_irq = 1'b0;
        exp_write(3'd0, 16'h0000);
        m_tick++;
    endtask

    task automatic do_snap(input logic [15:0] lo, input logic [15:0] hi);
        slave_lo = lo;
        slave_hi = hi;
        cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        cyc(4);
        exp_snapshot(lo, hi);
        check_snap("snap", 1'b1);
    endtask

    // Requests during SNAPL and SNAPH merge into a single follow-up snapshot.
    task automatic do_snap_merge(input logic [15:0] lo, input logic [15:0] hi);
        slave_lo = lo;
        slave_hi = hi;
        cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        cyc();
        cmd_snap = 1'b1;
        cyc(2);
        cmd_snap = 1'b0;
        cyc(6);
        exp_snapshot(lo, hi);
        exp_snapshot(lo, hi);
        check_snap("snap_merge", 1'b1);
    endtask

    // Timeout outranks a snapshot request in the same cycle.
    task automatic do_irq_snap(input logic [15:0] lo, input logic [15:0] hi);
        slave_lo  = lo;
        slave_hi  = hi;
        timer_irq = 1'b1;
        cmd_snap  = 1'b1;
        cyc();
        timer_irq = 1'b0;
        cmd_snap  = 1'b0;
        cyc(6);
        exp_write(3'd0, 16'h0000);
        m_tick++;
        exp_snapshot(lo, hi);
        check_snap("irq_snap", 1'b1);
    endtask

    initial begin
        int start_cycle;
        logic [31:0] p;

        reset_n   = 1'b0;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_snap  = 1'b0;
        timer_irq = 1'b0;
        period    = 32'h0;
        cyc(3);
        check_ticks("reset_tick");
        check_status("reset", 1'b0, 1'b0);
        check_snap("reset_snap", 1'b0);
        check("reset_cs", 64'({avm_chipselect, avm_chipselect4}), 64'(2'b00));
        reset_n = 1'b1;
        cyc(2);

        // Programming sequence: five back-to-back writes, then running.
        start_cycle = cycle_no;
        do_start(32'h0001_86A0);
        for (int i = 0; i < act_t.size(); i++)
            check("program_stamp", 64'(act_t[i]), 64'(start_cycle + 1 + i));
        compare_bus("program");
        check_status("program", 1'b1, 1'b1);

        // Three two-cycle timeouts, each counted once.
        repeat (3) do_irq(1'b1);
        compare_bus("irq3");
        check_ticks("irq3_tick");

        // cmd_start while running is ignored.
        cmd_start = 1'b1;
        period    = $urandom();
        cyc();
        cmd_start = 1'b0;
        cyc(3);
        compare_bus("start_ignored");
        check_ticks("start_ignored_tick");

        // Directed snapshot and pulse width.
        do_snap(16'h1234, 16'h0005);
        check("snap_directed", 64'(snap_value), 64'(32'h0005_1234));
        cyc();
        check_snap("snap_pulse_end", 1'b0);
        compare_bus("snap");

        // Randomized run-phase operations.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: do_irq(1'($urandom()));
                1: do_snap(16'($urandom()), 16'($urandom()));
                2: do_snap_merge(16'($urandom()), 16'($urandom()));
                default: do_irq_snap(16'($urandom()), 16'($urandom()));
            endcase
            cyc($urandom_range(0, 3));
        end
        compare_bus("random");
        check_ticks("random_tick");
        check_status("random", 1'b1, 1'b1);

        // 4-bit counter wraps from 15 to 0.
        while (m_tick[3:0] != 4'hF) do_irq(1'($urandom()));
        check("wrap_at15", 64'(tick4), 64'(4'hF));
        do_irq(1'b1);
        check("wrap_to0", 64'(tick4), 64'(4'h0));
        check_ticks("wrap_tick");
        compare_bus("wrap");

        // Stop during SNAPL: snapshot completes, then HALT.
        slave_lo = 16'($urandom());
        slave_hi = 16'($urandom());
        cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        cyc();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        cyc(4);
        exp_snapshot(slave_lo, slave_hi);
        exp_write(3'd1, 16'h0008);
        compare_bus("stop_in_snap");
        check_status("stop_in_snap", 1'b0, 1'b0);
        check("stop_in_snap_value", 64'(snap_value), 64'(m_snap));

        // Commands and irq in IDLE are ignored.
        cmd_stop  = 1'b1;
        cmd_snap  = 1'b1;
        timer_irq = 1'b1;
        cyc();
        cmd_stop  = 1'b0;
        cmd_snap  = 1'b0;
        timer_irq = 1'b0;
        cyc(3);
        compare_bus("idle_ignore");
        check_status("idle_ignore", 1'b0, 1'b0);

        // Restart, then irq and stop together: HALT wins, no count.
        p = $urandom();
        do_start(p);
        do_irq(1'b0);
        do_irq(1'b1);
        timer_irq = 1'b1;
        cmd_stop  = 1'b1;
        cyc();
        timer_irq = 1'b0;
        cmd_stop  = 1'b0;
        cyc();
        exp_write(3'd1, 16'h0008);
        compare_bus("irq_stop");
        check_ticks("irq_stop_tick");
        check_status("irq_stop", 1'b0, 1'b0);

        // Reset while in PH abandons the sequence.
        p = $urandom();
        cmd_start = 1'b1;
        period    = p;
        cyc();
        cmd_start = 1'b0;
        cyc(2);
        reset_n = 1'b0;
        #1;
        m_tick = 32'h0;
        m_snap = 32'h0;
        check("ph_reset_bus", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
              64'({1'b0, 1'b1, 3'd0, 16'h0}));
        check("ph_reset_bus4", 64'({avm_chipselect4, avm_write_n4, avm_address4, avm_writedata4}),
              64'({1'b0, 1'b1, 3'd0, 16'h0}));
        check_ticks("ph_reset_tick");
        check_status("ph_reset", 1'b0, 1'b0);
        check_snap("ph_reset_snap", 1'b0);
        exp_write(3'd1, 16'h0008);
        exp_write(3'd2, p[15:0]);
        exp_write(3'd3, p[31:16]);
        cyc();
        reset_n = 1'b1;
        cyc(8);
        compare_bus("ph_reset");
        check_status("after_reset", 1'b0, 1'b0);

        check("valid_pulses", 64'(valid_pulses), 64'(m_pulses));
        check("valid_pulses4", 64'(valid_pulses4), 64'(m_pulses));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
